// File: rtl/alarm_timer_server_if.sv
// Purpose: control/status bundle between the alarm FSM and alarm_timer_server.
// Latency: none, this is wiring only.
// Backpressure: none; start_timer and reprogram are level strobes sampled every clock.
interface alarm_timer_server_if;
    logic       start_timer;
    logic [1:0] interval;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       expired;
    logic       one_hz_enable;
    logic [3:0] value;
    logic [3:0] time_readback;

    // Alarm FSM side: issues requests, observes the timer.
    modport master (
        output start_timer, interval, reprogram, time_param_sel, time_value,
        input  expired, one_hz_enable, value, time_readback
    );

    // Timer side.
    modport slave (
        input  start_timer, interval, reprogram, time_param_sel, time_value,
        output expired, one_hz_enable, value, time_readback
    );
endinterface

// File: rtl/alarm_timer_server.sv
// Purpose: seconds countdown timer with a 4-entry interval table (CLK_DIV clocks per second).
// Latency: load on the start_timer edge; expired rises exactly N*CLK_DIV clocks after that edge.
// Backpressure: none; start_timer is level-sampled and reloads on every high cycle.
// ALARM_TIMER_REPROGRAM_EN: defined makes the interval table writable; undefined keeps it at the defaults.
module alarm_timer_server #(
    parameter int CLK_DIV      = 50000000,
    parameter int T_ARM_DEF    = 6,
    parameter int T_DRIVER_DEF = 8,
    parameter int T_PASS_DEF   = 15,
    parameter int T_ALARM_DEF  = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    alarm_timer_server_if.slave  bus
);
    localparam int            PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [3:0]    value_q;
    logic          expired_q;
    logic [3:0]    tbl [4];
    logic [3:0]    load_val;
    logic          tick;

    // Table read happens before any same-edge write lands, so a start that
    // coincides with a reprogram of the same entry loads the old value.
    assign load_val = tbl[bus.interval];

    // A start in the last prescaler cycle wins over the decrement, so no tick then.
    assign tick = (state == COUNT) && (presc == PS_LAST) && !bus.start_timer;

`ifdef ALARM_TIMER_REPROGRAM_EN
    // Writable interval table; a running countdown keeps its already-loaded value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tbl[0] <= 4'(T_ARM_DEF);
            tbl[1] <= 4'(T_DRIVER_DEF);
            tbl[2] <= 4'(T_PASS_DEF);
            tbl[3] <= 4'(T_ALARM_DEF);
        end else if (bus.reprogram) begin
            tbl[bus.time_param_sel] <= bus.time_value;
        end
    end
`else
    // Fixed interval table; the write port is left unconnected.
    logic unused_wr;
    assign unused_wr = ^{bus.reprogram, bus.time_value};
    assign tbl[0] = 4'(T_ARM_DEF);
    assign tbl[1] = 4'(T_DRIVER_DEF);
    assign tbl[2] = 4'(T_PASS_DEF);
    assign tbl[3] = 4'(T_ALARM_DEF);
`endif

    // Countdown FSM: start reloads from any state, COUNT ticks the prescaler,
    // IDLE/DONE park the prescaler at zero and hold value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            presc     <= '0;
            value_q   <= 4'd0;
            expired_q <= 1'b0;
        end else if (bus.start_timer) begin
            presc   <= '0;
            value_q <= load_val;
            if (load_val == 4'd0) begin
                state     <= DONE;
                expired_q <= 1'b1;
            end else begin
                state     <= COUNT;
                expired_q <= 1'b0;
            end
        end else begin
            case (state)
                COUNT: begin
                    if (presc == PS_LAST) begin
                        presc <= '0;
                        if (value_q != 4'd0) begin
                            value_q <= value_q - 4'd1;
                        end
                        if (value_q <= 4'd1) begin
                            state     <= DONE;
                            expired_q <= 1'b1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: begin
                    presc <= '0;
                end
            endcase
        end
    end

    assign bus.expired       = expired_q;
    assign bus.one_hz_enable = tick;
    assign bus.value         = value_q;
    assign bus.time_readback = tbl[bus.time_param_sel];
endmodule

// File: doc/alarm_timer_server.md
ALARM_TIMER_SERVER -- requirements
Module: alarm_timer_server

Interface
REQ-001 Parameter CLK_DIV, default 50000000, clock cycles per one-second tick (minimum 2).
REQ-002 Parameter T_ARM_DEF, default 6; T_DRIVER_DEF, default 8; T_PASS_DEF, default 15; T_ALARM_DEF, default 10; power-up seconds for interval codes 00/01/10/11.
REQ-003 clock  input  1  single system clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start_timer  input  1  request from the alarm FSM: (re)start countdown for the selected interval.
REQ-006 interval  input  2  interval code sampled with start_timer.
REQ-007 reprogram  input  1  write strobe for the parameter table.
REQ-008 time_param_sel  input  2  parameter index for write and readback.
REQ-009 time_value  input  4  seconds value written on reprogram.
REQ-010 expired  output  1  level, countdown finished; held until next start_timer or reset.
REQ-011 one_hz_enable  output  1  one-cycle tick every CLK_DIV cycles while counting.
REQ-012 value  output  4  remaining seconds of the running countdown.
REQ-013 time_readback  output  4  current table entry at time_param_sel (combinational read).

Function
REQ-014 Parameter table: four 4-bit registers, index = interval code; values 0..15 seconds.
REQ-015 State machine IDLE, COUNT, DONE; IDLE -> COUNT on start_timer with loaded value > 0; IDLE/COUNT/DONE -> DONE on start_timer with loaded value 0.
REQ-016 start_timer high at edge k: value = table[interval] after k, prescaler cleared, expired = 0 (or 1 if loaded value is 0), in every state.
REQ-017 start_timer is level-sampled; held high for several cycles, it reloads each cycle and countdown begins after its final high cycle.
REQ-018 In COUNT, prescaler counts 0..CLK_DIV-1; at count CLK_DIV-1 one_hz_enable pulses for that cycle and value decrements.
REQ-019 Decrement from 1 to 0: same edge sets expired = 1, state DONE; expiry occurs exactly N*CLK_DIV cycles after the loading edge.
REQ-020 In IDLE and DONE, prescaler is held at 0, one_hz_enable = 0, value holds.
REQ-021 Reprogram at edge k: table[time_param_sel] = time_value after k; a running countdown is not affected.
REQ-022 Simultaneous start_timer and reprogram at the same index: start loads the old table value; the new value applies from the next start.
REQ-023 value never wraps below 0; no decrement in DONE.

Reset
REQ-024 reset low: state IDLE, expired 0, one_hz_enable 0, value 0, prescaler 0, table = T_ARM_DEF/T_DRIVER_DEF/T_PASS_DEF/T_ALARM_DEF, immediately and asynchronously.
REQ-025 Reset asserted mid-countdown aborts it; after release no expired until a new start_timer.

Configuration
REQ-026 Macro ALARM_TIMER_REPROGRAM_EN defined: table writable per REQ-021/022.
REQ-027 Macro undefined: table constant at defaults, reprogram/time_value ignored, time_readback still reflects defaults.

Verification (CLK_DIV = 4)
REQ-028 Reset release, start_timer 1 cycle with interval=00 -> value 6, one_hz_enable every 4 cycles, expired rises exactly 24 cycles after load edge, value 0.
REQ-029 reprogram sel=11 value=3, then start interval=11 -> expired 12 cycles after load; time_readback=3 with sel=11.
REQ-030 Start interval=01 (8), restart with interval=00 after 10 cycles -> expired cleared, value 6, expiry 24 cycles after the restart.
REQ-031 reprogram sel=10 value=0, start interval=10 -> expired 1 on next edge, one_hz_enable never pulses.
REQ-032 Reset low at cycle 9 of a countdown -> all outputs 0 immediately, no expired for 50 cycles afterward without start.
REQ-033 Macro undefined: reprogram sel=00 value=2, start interval=00 -> expiry still 24 cycles, time_readback=6.
